serial_parity_checker: RTL and testbench
========================================

Name: serial_parity_checker

Overview:
- Parametrised successor to the single-bit serial parity FSM.
- Receives a framed serial stream on `x`, qualified by a bit strobe: start bit, DATA_BITS data bits (LSB first), one parity bit, one stop bit.
- Checks parity in a runtime-selectable even/odd mode, flags parity and framing errors, and keeps a saturating error count.
- Sits between a serial front end (bit-sync/oversampler) and the byte-level consumer.

Parameters:
- DATA_BITS, 8, data bits per frame (legal range 1..32).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- x  input  1  serial data bit.
- valid  input  1  bit strobe; `x` is sampled only on posedge `clk` when valid=1.
- odd_mode  input  1  0=even parity, 1=odd parity; latched at start-bit acceptance.
- clr_cnt  input  1  synchronous clear of err_count.
- z  output  1  running parity of data bits received so far in the current frame, XOR latched odd_mode.
- data_out  output  DATA_BITS  last completed frame's data word.
- frame_done  output  1  one-cycle pulse: a frame (good or bad) completed.
- parity_err  output  1  one-cycle pulse, coincident with frame_done.
- frame_err  output  1  one-cycle pulse, coincident with frame_done; stop bit was 0.
- err_count  output  ERR_CNT_W  saturating count of erroneous frames.

Behaviour:
- Reset (rst=1 at posedge):
  - FSM goes to IDLE.
  - z, data_out, frame_done, parity_err, frame_err, err_count all become 0.
  - Bit counter, shift register and latched mode are cleared.
  - Reset mid-frame discards the partial frame; no pulse and no count.
- Cycles with valid=0: no state change. Pulses still self-clear after one cycle.
- FSM states and transitions (each transition only on a valid=1 edge):
  - IDLE: x=0 is accepted as start bit and moves to DATA. On acceptance: latch odd_mode, clear shift register and bit counter, set z=odd_mode. x=1 stays in IDLE.
  - DATA: shift x into the shift register (LSB first) and set z <= z^x. After the DATA_BITS-th bit, move to PAR.
  - PAR: sample parity bit p. perr = XOR(data) ^ p ^ odd_latched. Move to STOP.
  - STOP: sample stop bit. ferr = ~x. Move to IDLE. On the next clock:
    - data_out <= assembled word;
    - frame_done=1, parity_err=perr, frame_err=ferr, each for exactly one cycle.
- Latency: the pulses are visible in the cycle immediately after the edge that samples the stop bit.
- Back-to-back frames:
  - A start bit may arrive on the valid edge immediately after the stop bit.
  - frame_done of frame N may be high in the same cycle frame N+1's start bit is accepted.
- z behaviour:
  - Holds its value through PAR, STOP and IDLE until the next start bit.
  - odd_mode changes mid-frame are ignored.
- err_count:
  - +1 per frame with perr|ferr; a frame with both errors still adds only 1.
  - Updates in the same cycle as frame_done.
  - Saturates at 2^ERR_CNT_W-1 and never wraps.
  - clr_cnt=1 sets it to 0. clr_cnt wins over a simultaneous increment (result 0).
- data_out holds until the next completed frame, including frames with errors.

Decomposition:
- Package serial_parity_pkg holds:
  - state encoding localparams ST_IDLE, ST_DATA, ST_PAR, ST_STOP (2-bit);
  - a function computing the bit-counter width as clog2(DATA_BITS+1).
- One sub-module, sat_counter (WIDTH parameter; inputs clk, rst, inc, clr; output cnt), holds the saturating error count.
- FSM, shifter and parity logic live in the top module.

Test Plan:
All scenarios use DATA_BITS=8 and ERR_CNT_W=8, with `valid` pulsed every cycle unless stated.
1. Good even frame:
   - Stimulus: odd_mode=0; send start 0, data 0xA5 LSB first (1,0,1,0,0,1,0,1), parity 0, stop 1.
   - Required: one cycle after stop, data_out=0xA5, frame_done=1, parity_err=0, frame_err=0, err_count=0; z=0 after the last data bit.
2. Odd-mode check:
   - Stimulus: odd_mode=1; data 0x01, parity 0, stop 1.
   - Required: parity_err=0. Repeat with parity 1: parity_err=1 and err_count=1.
3. Framing plus parity error:
   - Stimulus: even mode; data 0x03, parity 1, stop 0.
   - Required: parity_err=1, frame_err=1, err_count increments by exactly 1.
4. Gapped strobe and mode toggle:
   - Stimulus: valid asserted every 3rd cycle; odd_mode toggled mid-frame; data 0xFF, parity 0.
   - Required: the result equals the ungapped even-mode result (no error), and frame_done lasts one cycle.
5. Reset mid-frame:
   - Stimulus: assert rst after 4 data bits; then send a full good frame with data 0x5A.
   - Required: no pulse for the aborted frame; data_out=0x5A afterwards; err_count=0.
6. Saturation and clear:
   - Stimulus: send 260 bad-parity frames.
   - Required: err_count=255 and holds there. Then clr_cnt=1 coinciding with another bad frame's frame_done gives err_count=0.

Source files
------------

// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: state encoding and sizing helper shared by the serial parity checker
package serial_parity_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones; clear has priority over increment
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + WIDTH'(1);
    end

endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: framed serial receiver (start, LSB-first data, parity, stop)
// with even/odd parity check, error pulses and a saturating error count
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x,
    input  logic                 valid,
    input  logic                 odd_mode,
    input  logic                 clr_cnt,
    output logic                 z,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CW = cnt_width(DATA_BITS);

    logic [1:0]           state, nxt;
    logic [CW-1:0]        bcnt;
    logic [DATA_BITS-1:0] sh;
    logic                 odd_l, perr_q;
    logic                 last_bit, accept, shift_en, par_en, stop_en, err_inc;

    assign last_bit = bcnt == CW'(DATA_BITS - 1);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = !valid             ? state :
              state == ST_IDLE ? (x ? ST_IDLE : ST_DATA) :
              state == ST_DATA ? (last_bit ? ST_PAR : ST_DATA) :
              state == ST_PAR  ? ST_STOP : ST_IDLE;
    end

    always_comb begin
        accept   = valid && state == ST_IDLE && !x;
        shift_en = valid && state == ST_DATA;
        par_en   = valid && state == ST_PAR;
        stop_en  = valid && state == ST_STOP;
        err_inc  = stop_en && (perr_q || !x);
    end

    // z already carries odd_l ^ XOR(data), so the parity error is just z ^ p
    always_ff @(posedge clk) begin
        if (rst) begin
            z          <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            bcnt       <= '0;
            sh         <= '0;
            odd_l      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            frame_done <= stop_en;
            parity_err <= stop_en && perr_q;
            frame_err  <= stop_en && !x;
            if (accept) begin
                odd_l <= odd_mode;
                sh    <= '0;
                bcnt  <= '0;
                z     <= odd_mode;
            end
            if (shift_en) begin
                sh   <= DATA_BITS'({x, sh} >> 1);
                bcnt <= bcnt + CW'(1);
                z    <= z ^ x;
            end
            if (par_en)
                perr_q <= z ^ x ^ 1'b0;
            if (stop_en)
                data_out <= sh;
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (clr_cnt),
        .cnt (err_count)
    );

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: directed frames with hand-computed expectations
module tb_serial_parity_checker;

    logic       clk = 1'b0;
    logic       rst, x, valid, odd_mode, clr_cnt;
    logic       z, frame_done, parity_err, frame_err;
    logic [7:0] data_out, err_count;
    int         total = 0;
    int         bad = 0;

    serial_parity_checker #(.DATA_BITS(8), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .valid      (valid),
        .odd_mode   (odd_mode),
        .clr_cnt    (clr_cnt),
        .z          (z),
        .data_out   (data_out),
        .frame_done (frame_done),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap, input logic toggle);
        x = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        if (toggle) odd_mode = ~odd_mode;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap, input logic toggle);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap, toggle);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0, 0, 1'b0);
        send_byte(d, 0, 1'b0);
        send_bit(p, 0, 1'b0);
        send_bit(s, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; x = 1'b1; valid = 1'b0; odd_mode = 1'b0; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_z", z, 0);
        chk("rst_data", data_out, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_cnt", err_count, 0);

        // good even frame 0xA5
        send_bit(1'b0, 0, 1'b0);
        send_byte(8'hA5, 0, 1'b0);
        chk("t1_z_data", z, 0);
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        chk("t1_done", frame_done, 1);
        chk("t1_data", data_out, 8'hA5);
        chk("t1_perr", parity_err, 0);
        chk("t1_ferr", frame_err, 0);
        chk("t1_cnt", err_count, 0);
        chk("t1_z_hold", z, 0);
        @(posedge clk);
        #1;
        chk("t1_done_clr", frame_done, 0);

        // odd mode, data 0x01
        odd_mode = 1'b1;
        send_bit(1'b0, 0, 1'b0);
        chk("t2_z_start", z, 1);
        send_byte(8'h01, 0, 1'b0);
        chk("t2_z_data", z, 0);
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        chk("t2a_done", frame_done, 1);
        chk("t2a_perr", parity_err, 0);
        chk("t2a_cnt", err_count, 0);
        send_frame(8'h01, 1'b1, 1'b1);
        chk("t2b_perr", parity_err, 1);
        chk("t2b_ferr", frame_err, 0);
        chk("t2b_cnt", err_count, 1);

        // back-to-back start, then parity + framing error
        odd_mode = 1'b0;
        send_bit(1'b0, 0, 1'b0);
        chk("t3_z_start", z, 0);
        chk("t3_done_gone", frame_done, 0);
        send_bit(1'b1, 0, 1'b0);
        chk("t3_z_bit0", z, 1);
        send_bit(1'b1, 0, 1'b0);
        chk("t3_z_bit1", z, 0);
        for (int i = 0; i < 6; i++) send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        chk("t3_done", frame_done, 1);
        chk("t3_perr", parity_err, 1);
        chk("t3_ferr", frame_err, 1);
        chk("t3_data", data_out, 8'h03);
        chk("t3_cnt", err_count, 2);

        // gapped strobe with odd_mode toggling mid-frame
        odd_mode = 1'b0;
        send_bit(1'b0, 2, 1'b1);
        send_byte(8'hFF, 2, 1'b1);
        send_bit(1'b0, 2, 1'b1);
        send_bit(1'b1, 0, 1'b0);
        chk("t4_done", frame_done, 1);
        chk("t4_perr", parity_err, 0);
        chk("t4_ferr", frame_err, 0);
        chk("t4_data", data_out, 8'hFF);
        chk("t4_cnt", err_count, 2);
        chk("t4_z", z, 0);
        @(posedge clk);
        #1;
        chk("t4_done_1cyc", frame_done, 0);

        // reset mid-frame
        odd_mode = 1'b0;
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_done_rst", frame_done, 0);
        chk("t5_data_rst", data_out, 0);
        chk("t5_cnt_rst", err_count, 0);
        chk("t5_z_rst", z, 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        chk("t5_done", frame_done, 1);
        chk("t5_data", data_out, 8'h5A);
        chk("t5_perr", parity_err, 0);
        chk("t5_cnt", err_count, 0);

        // saturation and clear
        for (int i = 0; i < 260; i++) begin
            send_frame(8'h00, 1'b1, 1'b1);
            if (i == 253) chk("t6_cnt_254", err_count, 254);
        end
        chk("t6_cnt_sat", err_count, 255);
        chk("t6_perr", parity_err, 1);
        send_bit(1'b0, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        clr_cnt = 1'b1;
        send_bit(1'b1, 0, 1'b0);
        clr_cnt = 1'b0;
        chk("t6_clr_done", frame_done, 1);
        chk("t6_clr_perr", parity_err, 1);
        chk("t6_clr_cnt", err_count, 0);
        send_frame(8'h00, 1'b1, 1'b1);
        chk("t6_after_clr", err_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
